// File: rtl/pixel_scaler_2x2_pkg.sv
// Shared codes for the 2x2 tile scaler: modes, FSM states, tile positions
// and the select codes of the per-channel averaging unit.
package pixel_scaler_2x2_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_AVG4   = 2'b01,
        MODE_INTERP = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        POS_A = 2'd0,
        POS_B = 2'd1,
        POS_C = 2'd2,
        POS_D = 2'd3
    } pos_t;

    // averaging unit select: (a+c)>>1, (a+b)>>1, (a+b+c+d)>>2
    localparam logic [1:0] SEL_AC   = 2'b00;
    localparam logic [1:0] SEL_AB   = 2'b01;
    localparam logic [1:0] SEL_SUM4 = 2'b10;

    // the reserved mode code behaves exactly like pass-through
    function automatic mode_t norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_PASS : mode_t'(m);
    endfunction

endpackage

// File: rtl/pixel_scaler_2x2_avg_unit.sv
// One colour channel of the scaler arithmetic: 2-tap or 4-tap unsigned
// average with optional round-half-up, result truncated back to DW bits.
module scaler_avg_unit
    import pixel_scaler_2x2_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ROUND = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    input  logic [1:0]    sel,
    output logic [DW-1:0] y
);

    localparam logic [DW+1:0] RND2 = {{(DW+1){1'b0}}, (ROUND != 0)};
    localparam logic [DW+1:0] RND4 = {{DW{1'b0}}, (ROUND != 0), 1'b0};

    logic [DW+1:0] sum2;
    logic [DW+1:0] sum4;

    // two extra bits hold the 4-tap sum plus rounding without overflow
    always_comb begin
        sum2 = {2'b00, a} + {2'b00, (sel == SEL_AB) ? b : c} + RND2;
        sum4 = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + RND4;
        y    = (sel == SEL_SUM4) ? DW'(sum4 >> 2) : DW'(sum2 >> 1);
    end

endmodule

// File: rtl/pixel_scaler_2x2.sv
// Streaming 2x2 tile rescaler: collects A,B,C,D and emits pass-through,
// 4:1 average or 2-tap interpolated pixels through a registered output.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_COLLECT | accepting tile pixels A..D, no output pending
//   ST_EMIT    | presenting the tile's output pixels, input stalled
module pixel_scaler_2x2
    import pixel_scaler_2x2_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CH    = 3,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*DW-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*DW-1:0] out_pixel,
    output logic             out_last
);

    localparam int PW = CH * DW;

    state_t          state, state_nxt;
    pos_t            idx;
    mode_t           tile_mode;
    logic [1:0]      out_cnt;
    logic [PW-1:0]   tile [4];

    logic            in_xfer;
    logic            out_xfer;
    logic [1:0]      load_k;
    logic [1:0]      avg_sel;
    logic [PW-1:0]   d_op;
    logic [PW-1:0]   avg_pixel;
    logic [PW-1:0]   nxt_pixel;
    logic            nxt_last;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_COLLECT;
        else        state <= state_nxt;
    end

    // next state and handshake; enable low overrides any transfer
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        in_xfer   = 1'b0;
        out_xfer  = 1'b0;
        case (state)
            ST_COLLECT: begin
                in_ready = enable;
                in_xfer  = in_valid && enable;
                if (in_xfer && idx == POS_D) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                out_xfer = out_valid && out_ready && enable;
                if (out_xfer && out_last) state_nxt = ST_COLLECT;
            end
            default: state_nxt = ST_COLLECT;
        endcase
        if (!enable) state_nxt = ST_COLLECT;
    end

    // pick the next output pixel; while D is arriving it comes straight
    // from the input so the first result is ready on the same edge
    always_comb begin
        load_k  = (state == ST_COLLECT) ? 2'd0 : out_cnt + 2'd1;
        d_op    = (state == ST_COLLECT) ? in_pixel : tile[3];
        avg_sel = SEL_AC;
        if (tile_mode == MODE_AVG4)  avg_sel = SEL_SUM4;
        else if (load_k != 2'd0)     avg_sel = SEL_AB;
        case (tile_mode)
            MODE_AVG4: begin
                nxt_pixel = avg_pixel;
                nxt_last  = 1'b1;
            end
            MODE_INTERP: begin
                nxt_pixel = avg_pixel;
                nxt_last  = (load_k == 2'd1);
            end
            default: begin
                nxt_pixel = tile[load_k];
                nxt_last  = (load_k == 2'd3);
            end
        endcase
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        scaler_avg_unit #(.DW(DW), .ROUND(ROUND)) u_avg (
            .a   (tile[0][g*DW +: DW]),
            .b   (tile[1][g*DW +: DW]),
            .c   (tile[2][g*DW +: DW]),
            .d   (d_op[g*DW +: DW]),
            .sel (avg_sel),
            .y   (avg_pixel[g*DW +: DW])
        );
    end

    // tile buffer, position/output counters and the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= POS_A;
            tile_mode <= MODE_PASS;
            out_cnt   <= 2'd0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < 4; i++) tile[i] <= '0;
        end else if (!enable) begin
            idx       <= POS_A;
            out_cnt   <= 2'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (in_xfer) begin
                tile[idx] <= in_pixel;
                idx       <= pos_t'(idx + 2'd1);
                if (idx == POS_A) tile_mode <= norm_mode(mode);
                if (idx == POS_D) begin
                    out_valid <= 1'b1;
                    out_pixel <= nxt_pixel;
                    out_last  <= nxt_last;
                    out_cnt   <= 2'd0;
                end
            end
            if (out_xfer) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_cnt   <= out_cnt + 2'd1;
                    out_pixel <= nxt_pixel;
                    out_last  <= nxt_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_scaler_2x2.sv
// Directed bench: one truncating and one rounding scaler share the same
// stimulus; each output is compared with hand-computed values.
module tb_pixel_scaler_2x2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        in_valid = 1'b0;
    logic [23:0] in_pixel = '0;
    logic        out_ready = 1'b1;

    logic        rdy0, v0, last0;
    logic        rdy1, v1, last1;
    logic [23:0] pix0, pix1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pixel_scaler_2x2 #(.DW(8), .CH(3), .ROUND(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy0), .in_pixel(in_pixel),
        .out_valid(v0), .out_ready(out_ready), .out_pixel(pix0), .out_last(last0)
    );

    pixel_scaler_2x2 #(.DW(8), .CH(3), .ROUND(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy1), .in_pixel(in_pixel),
        .out_valid(v1), .out_ready(out_ready), .out_pixel(pix1), .out_last(last1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [23:0] p);
        int cnt = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_pixel = p;
        while (!rdy0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check("push_timeout", cnt, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push4(input logic [23:0] a, b, c, d);
        push(a); push(b); push(c); push(d);
    endtask

    task automatic pop(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                       input logic exp_last);
        int cnt = 0;
        @(negedge clk);
        while (!v0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_valid0"}, v0, 1);
        check({tag, "_valid1"}, v1, 1);
        check({tag, "_pix0"}, pix0, e0);
        check({tag, "_pix1"}, pix1, e1);
        check({tag, "_last0"}, last0, exp_last);
        check({tag, "_last1"}, last1, exp_last);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, "_idle_valid"}, v0, 0);
        check({tag, "_idle_ready"}, rdy0, 1);
    endtask

    initial begin
        // reset state
        #12;
        check("rst_valid", v0, 0);
        check("rst_pixel", pix0, 0);
        check("rst_last", last0, 0);
        check("rst_ready", rdy0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: pass-through
        mode = 2'b00;
        push4(24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0);
        pop("pass0", 24'h102030, 24'h102030, 0);
        pop("pass1", 24'h405060, 24'h405060, 0);
        pop("pass2", 24'h708090, 24'h708090, 0);
        pop("pass3", 24'hA0B0C0, 24'hA0B0C0, 1);
        expect_idle("pass");

        // 2: 4:1 average; ch0 1,2,3,3 ; ch1 1,2,3,4 ; ch2 all FF
        mode = 2'b01;
        push4(24'hFF0101, 24'hFF0202, 24'hFF0303, 24'hFF0403);
        pop("avg", 24'hFF0202, 24'hFF0302, 1);
        expect_idle("avg");
        push4(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        pop("avg_ff", 24'hFFFFFF, 24'hFFFFFF, 1);
        expect_idle("avg_ff");

        // 3: interpolation
        mode = 2'b10;
        push4(24'h101010, 24'h212121, 24'h313131, 24'h999999);
        pop("interp_ac", 24'h202020, 24'h212121, 0);
        pop("interp_ab", 24'h181818, 24'h191919, 1);
        expect_idle("interp");

        // reserved mode code behaves as pass-through
        mode = 2'b11;
        push4(24'h000001, 24'h000002, 24'h000003, 24'h000004);
        pop("rsvd0", 24'h000001, 24'h000001, 0);
        pop("rsvd1", 24'h000002, 24'h000002, 0);
        pop("rsvd2", 24'h000003, 24'h000003, 0);
        pop("rsvd3", 24'h000004, 24'h000004, 1);

        // 4: backpressure mid-emit
        mode = 2'b00;
        push4(24'h111111, 24'h222222, 24'h333333, 24'h444444);
        pop("bp0", 24'h111111, 24'h111111, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_hold_pix", pix0, 24'h222222);
            check("bp_hold_valid", v0, 1);
            check("bp_hold_last", last0, 0);
            check("bp_in_ready", rdy0, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        pop("bp2", 24'h333333, 24'h333333, 0);
        pop("bp3", 24'h444444, 24'h444444, 1);
        expect_idle("bp");

        // 5: mode change after B is ignored until the next A
        mode = 2'b00;
        push(24'h010203);
        push(24'h040506);
        mode = 2'b01;
        push(24'h070809);
        push(24'h0A0B0C);
        pop("msw0", 24'h010203, 24'h010203, 0);
        pop("msw1", 24'h040506, 24'h040506, 0);
        pop("msw2", 24'h070809, 24'h070809, 0);
        pop("msw3", 24'h0A0B0C, 24'h0A0B0C, 1);
        push4(24'h040404, 24'h080808, 24'h0C0C0C, 24'h101010);
        pop("msw_avg", 24'h0A0A0A, 24'h0A0A0A, 1);
        expect_idle("msw");

        // 6a: abort after C, next tile starts from A
        mode = 2'b00;
        push(24'h0000AA);
        push(24'h0000BB);
        push(24'h0000CC);
        @(negedge clk);
        enable = 1'b0;
        #1;
        check("abort_ready", rdy0, 0);
        @(negedge clk);
        enable = 1'b1;
        check("abort_valid", v0, 0);
        push4(24'h0A0000, 24'h0B0000, 24'h0C0000, 24'h0D0000);
        pop("abort0", 24'h0A0000, 24'h0A0000, 0);
        pop("abort1", 24'h0B0000, 24'h0B0000, 0);
        pop("abort2", 24'h0C0000, 24'h0C0000, 0);
        pop("abort3", 24'h0D0000, 24'h0D0000, 1);
        expect_idle("abort");

        // 6b: abort discards a pending output
        push4(24'h123456, 24'h123456, 24'h123456, 24'h123456);
        @(negedge clk);
        check("abort_emit_pending", v0, 1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_emit_valid", v0, 0);
        enable = 1'b1;
        expect_idle("abort_emit");

        // 6c: asynchronous reset mid-emit
        push4(24'h5A5A5A, 24'h6B6B6B, 24'h7C7C7C, 24'h8D8D8D);
        @(negedge clk);
        check("rst_emit_pending", v0, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", v0, 0);
        check("rst_async_pixel", pix0, 0);
        check("rst_async_last", last0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", rdy0, 1);
        push4(24'h0F0F0F, 24'h1F1F1F, 24'h2F2F2F, 24'h3F3F3F);
        pop("post_rst0", 24'h0F0F0F, 24'h0F0F0F, 0);
        pop("post_rst1", 24'h1F1F1F, 24'h1F1F1F, 0);
        pop("post_rst2", 24'h2F2F2F, 24'h2F2F2F, 0);
        pop("post_rst3", 24'h3F3F3F, 24'h3F3F3F, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
